// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (if_*) and
//   load/store (d_*). One transaction at a time; data wins ties because the
//   load/store belongs to the older instruction. Completion is signalled by a
//   one-cycle ack pulse in a dedicated DONE cycle, during which no grant is
//   made, so a requester still holding req while it samples ack is not
//   served twice.
//
//   Optional build macro: ARB_TIMEOUT_EN
//     defined   - a BUSY phase without mem_ack for TIMEOUT cycles completes
//                 with rdata all ones and sets sticky bus_err.
//     undefined - BUSY waits forever for mem_ack, bus_err stays 0.
//
//   Ports
//     clk, rst        clock (rising edge), async active-high reset
//     if_req/if_addr  fetch request, held until if_ack
//     if_rdata/if_ack fetched word, one-cycle completion pulse
//     d_req/d_we/d_be/d_addr/d_wdata  load/store request, held until d_ack
//     d_rdata/d_ack   load data (untouched by stores), completion pulse
//     mem_*           memory handshake; mem_req held until mem_ack
//     stall           combinational core freeze while any request is pending
//     bus_err         sticky timeout flag
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ack,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ack,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   output logic                stall,
   output logic                bus_err
);

   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT must be at least 2");
   end

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

   state_t state, state_nx;
   logic   busy;
   logic   tmo;   // BUSY phase expires this cycle with no mem_ack

   assign busy = (state == BUSY_I) || (state == BUSY_D);

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;

   // BUSY is only ever entered from IDLE, so clearing outside BUSY is the
   // same as clearing on entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (!busy)
         cnt <= '0;
      else if (!mem_ack)
         cnt <= cnt + 1'b1;
   end

   // cnt counts completed ack-less BUSY cycles; this is the TIMEOUT-th one.
   assign tmo = busy && !mem_ack && (cnt == CW'(TIMEOUT - 1));
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:           if (d_req)           state_nx = BUSY_D;
                         else if (if_req)     state_nx = BUSY_I;
         BUSY_I, BUSY_D: if (mem_ack || tmo)  state_nx = DONE;
         default:                             state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         bus_err   <= 1'b0;
      end else begin
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         case (state)
            IDLE: begin
               if (d_req) begin
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_be    <= d_we ? d_be : '1;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
               end else if (if_req) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_be    <= '1;
                  mem_addr  <= if_addr;
               end
            end
            BUSY_I: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  if_rdata <= mem_rdata;
                  if_ack   <= 1'b1;
               end else if (tmo) begin
                  mem_req  <= 1'b0;
                  if_rdata <= '1;
                  if_ack   <= 1'b1;
                  bus_err  <= 1'b1;
               end
            end
            BUSY_D: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (!mem_we) d_rdata <= mem_rdata;
                  d_ack   <= 1'b1;
               end else if (tmo) begin
                  mem_req <= 1'b0;
                  d_rdata <= '1;
                  d_ack   <= 1'b1;
                  bus_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A memory responder acks after a
// programmable number of mem_req cycles and keeps its own byte-enabled
// storage; the reference model keeps a separate word map updated at the
// transaction level and predicts ack cycles, memory windows and read data.
module tb_mem_port_arbiter;
   localparam int AW = 32, DW = 32, BW = 4, TMO = 16;

   logic clk = 1'b0;
   logic rst;
   logic if_req, d_req, d_we, if_ack, d_ack, mem_req, mem_we, mem_ack, stall, bus_err;
   logic [AW-1:0] if_addr, d_addr, mem_addr;
   logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
   logic [BW-1:0] d_be, mem_be;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall(stall), .bus_err(bus_err)
   );

   int checks = 0, errors = 0;
   int ack_dly = 0, wcnt = 0;
   bit no_ack = 0, stray_ack = 0, exp_berr = 0;
   logic [31:0] phys [logic [31:0]];
   logic [31:0] refm [logic [31:0]];
   logic [31:0] ref_drd = '0;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] phys_rd(input logic [31:0] a);
      return phys.exists(a) ? phys[a] : init_val(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return refm.exists(a) ? refm[a] : init_val(a);
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory responder: acks once ack_dly mem_req cycles have elapsed.
   initial begin
      mem_ack = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0; mem_rdata = $urandom;
         if (stray_ack) begin
            mem_ack = 1'b1; stray_ack = 0;
         end else if (mem_req && !rst && !no_ack) begin
            if (wcnt >= ack_dly) begin
               mem_ack = 1'b1; wcnt = 0;
               if (mem_we) phys[mem_addr] = merge(phys_rd(mem_addr), mem_wdata, mem_be);
               else        mem_rdata = phys_rd(mem_addr);
            end else wcnt++;
         end else wcnt = 0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // One arbitration episode starting from IDLE. Cycle 0 raises the
   // requests; expected cycles follow from the 3-cycle minimum latency and
   // data-before-fetch ordering. Each requester drops req right after the
   // cycle it sees its ack, i.e. req is still high while ack is sampled.
   task automatic txn(input bit di, input bit dd, input bit we, input logic [3:0] be,
                      input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                      input int dly);
      int dack_c, iack_c, last, d0, d1, i0, i1;
      logic [31:0] exp_i;
      ack_dly = dly;
      dack_c = -1; iack_c = -1; d0 = -1; d1 = -2; i0 = -1; i1 = -2; exp_i = '0;
      if (dd) begin
         d0 = 1; d1 = 1 + dly; dack_c = 2 + dly;
         if (we) refm[da] = merge(ref_rd(da), wd, be);
         else    ref_drd = ref_rd(da);
      end
      if (di) begin
         i0 = dd ? 4 + dly : 1; i1 = i0 + dly; iack_c = i1 + 1;
         exp_i = ref_rd(ia);
      end
      last = (iack_c > dack_c) ? iack_c : dack_c;
      for (int c = 0; c <= last + 3; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            if_req = di; if_addr = ia;
            d_req = dd; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
         end
         if (c == dack_c + 1) d_req = 1'b0;
         if (c == iack_c + 1) if_req = 1'b0;
         @(negedge clk);
         chk1("stall", stall, (di && c < iack_c) || (dd && c < dack_c));
         chk1("if_ack", if_ack, c == iack_c);
         chk1("d_ack", d_ack, c == dack_c);
         chk1("mem_req", mem_req, (c >= d0 && c <= d1) || (c >= i0 && c <= i1));
         chk1("bus_err", bus_err, exp_berr);
         if (c >= d0 && c <= d1) begin
            chk32("d_mem_addr", mem_addr, da);
            chk1("d_mem_we", mem_we, we);
            chk32("d_mem_be", 32'(mem_be), 32'(we ? be : 4'hF));
            if (we) chk32("d_mem_wdata", mem_wdata, wd);
         end
         if (c >= i0 && c <= i1) begin
            chk32("i_mem_addr", mem_addr, ia);
            chk1("i_mem_we", mem_we, 1'b0);
            chk32("i_mem_be", 32'(mem_be), 32'hF);
         end
         if (c == iack_c) chk32("if_rdata", if_rdata, exp_i);
         if (!dd || we || c >= dack_c) chk32("d_rdata", d_rdata, ref_drd);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; ref_drd = '0; exp_berr = 0;
   endtask

   initial begin
      logic [31:0] ra, rb, rw;
      int k;
      rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; d_be = '0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      phys[32'h10] = 32'h0050_0093; refm[32'h10] = 32'h0050_0093;

      // Reset state, during and on the first edge after release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk32("rst_mem_addr", mem_addr, '0);
      chk32("rst_mem_be", 32'(mem_be), '0);
      chk1("rst_acks", if_ack | d_ack, 1'b0);
      chk32("rst_rdata", if_rdata | d_rdata, '0);
      chk1("rst_stall", stall, 1'b0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk1("rel_mem_req", mem_req, 1'b0);
      chk1("rel_mem_we", mem_we, 1'b0);
      chk32("rel_mem_wdata", mem_wdata, '0);
      chk1("rel_bus_err", bus_err, 1'b0);

      // Fetch at 0x10, memory acks one cycle after mem_req.
      txn(1, 0, 0, 4'h0, 32'h10, 32'h0, 32'h0, 1);
      // Collision: load 0x100 beats fetch 0x14.
      txn(1, 1, 0, 4'hF, 32'h14, 32'h100, 32'h0, 0);
      // Store with 5-cycle delayed ack, then read it back through a load.
      txn(0, 1, 1, 4'b0011, 32'h0, 32'h200, 32'hAABB_CCDD, 5);
      txn(0, 1, 0, 4'hF, 32'h0, 32'h200, 32'h0, 2);

      // Randomized episodes over a small address pool to force reuse.
      for (int n = 0; n < 40; n++) begin
         k  = $urandom_range(0, 3);
         ra = 32'h100 + 32'($urandom_range(0, 3)) * 4;
         rb = 32'h100 + 32'($urandom_range(0, 3)) * 4;
         rw = $urandom;
         case (k)
            0: txn(1, 0, 0, 4'hF, ra, rb, rw, $urandom_range(0, 4));
            1: txn(0, 1, 0, 4'hF, ra, rb, rw, $urandom_range(0, 4));
            2: txn(0, 1, 1, 4'($urandom_range(1, 15)), ra, rb, rw, $urandom_range(0, 4));
            default: txn(1, 1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                         ra, rb, rw, $urandom_range(0, 4));
         endcase
      end

      // Reset in the middle of a load; a stray ack afterwards is ignored.
      no_ack = 1;
      @(posedge clk); #1;
      d_req = 1; d_we = 0; d_addr = 32'h300;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      chk1("mid_mem_req", mem_req, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1; d_req = 1'b0;
      #1;
      chk1("mid_rst_mem_req", mem_req, 1'b0);
      chk1("mid_rst_d_ack", d_ack, 1'b0);
      chk1("mid_rst_bus_err", bus_err, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; no_ack = 0; ref_drd = '0;
      @(negedge clk);
      stray_ack = 1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); @(negedge clk);
         chk1("stray_mem_req", mem_req, 1'b0);
         chk1("stray_acks", if_ack | d_ack, 1'b0);
      end
      txn(1, 0, 0, 4'h0, 32'h10, 32'h0, 32'h0, 0);

      // Memory never answers.
      no_ack = 1;
      @(posedge clk); #1;
      d_req = 1; d_we = 0; d_addr = 32'h400;
`ifdef ARB_TIMEOUT_EN
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (c == 18) d_req = 1'b0;
         @(negedge clk);
         chk1("tmo_mem_req", mem_req, c <= TMO);
         chk1("tmo_d_ack", d_ack, c == TMO + 1);
         chk1("tmo_bus_err", bus_err, c >= TMO + 1);
         if (c == TMO + 1) chk32("tmo_d_rdata", d_rdata, 32'hFFFF_FFFF);
      end
      no_ack = 0; exp_berr = 1; ref_drd = 32'hFFFF_FFFF;
      txn(1, 0, 0, 4'h0, 32'h10, 32'h0, 32'h0, 1);
      do_reset();
      @(negedge clk);
      chk1("tmo_err_cleared", bus_err, 1'b0);
`else
      for (int c = 1; c <= 105; c++) begin
         @(posedge clk); @(negedge clk);
         chk1("hang_mem_req", mem_req, 1'b1);
         chk1("hang_d_ack", d_ack, 1'b0);
         chk1("hang_bus_err", bus_err, 1'b0);
      end
      no_ack = 0;
      do_reset();
`endif
      txn(0, 1, 0, 4'hF, 32'h0, 32'h10, 32'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
